// File: rtl/mips_multi_cycle.sv
// Multi-cycle MIPS-I subset core with one shared req/ready memory port and precise exceptions.
// Optional performance counters are enabled by defining MC_MIPS_PERF_COUNTERS_EN.
module mips_multi_cycle #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0180,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ready,
    output logic [31:0]           pc,
    output logic [31:0]           epc,
    output logic [4:0]            cause,
    output logic                  exc_pulse
`ifdef MC_MIPS_PERF_COUNTERS_EN
    ,
    output logic [31:0]           cycle_cnt,
    output logic [31:0]           instret_cnt
`endif
);

    localparam logic [2:0] S_FETCH     = 3'd0;
    localparam logic [2:0] S_DECODE    = 3'd1;
    localparam logic [2:0] S_EXECUTE   = 3'd2;
    localparam logic [2:0] S_MEM       = 3'd3;
    localparam logic [2:0] S_WRITEBACK = 3'd4;
    localparam logic [2:0] S_EXCEPTION = 3'd5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d, ipc_q, ipc_d, ir_q, ir_d;
    logic [31:0] a_q, a_d, b_q, b_d, aluout_q, aluout_d, mdr_q, mdr_d;
    logic [31:0] epc_q, epc_d;
    logic [4:0]  cause_q, cause_d, exc_code_q, exc_code_d;
    logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d, exc_pulse_q, exc_pulse_d;
    logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, wb_addr;
    logic [31:0] sext_imm, a_plus_imm, a_plus_b, a_minus_b, wb_data;
    logic [31:0] alu_result;
    logic        alu_ovf, insn_valid;

    assign opcode     = ir_q[31:26];
    assign rs         = ir_q[25:21];
    assign rt         = ir_q[20:16];
    assign rd         = ir_q[15:11];
    assign funct      = ir_q[5:0];
    assign sext_imm   = {{16{ir_q[15]}}, ir_q[15:0]};
    assign a_plus_imm = a_q + sext_imm;
    assign a_plus_b   = a_q + b_q;
    assign a_minus_b  = a_q - b_q;
    assign wb_addr    = (opcode == OP_RTYPE) ? rd : rt;
    assign wb_data    = (opcode == OP_LW) ? mdr_q : aluout_q;

    always_comb begin
        case (opcode)
            OP_RTYPE: insn_valid = funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
            OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW: insn_valid = 1'b1;
            default:  insn_valid = 1'b0;
        endcase
    end

    always_comb begin
        alu_result = '0;
        alu_ovf    = 1'b0;
        if (opcode == OP_ADDI) begin
            alu_result = a_plus_imm;
            alu_ovf    = (a_q[31] == sext_imm[31]) && (a_plus_imm[31] != a_q[31]);
        end else begin
            case (funct)
                FN_ADD: begin
                    alu_result = a_plus_b;
                    alu_ovf    = (a_q[31] == b_q[31]) && (a_plus_b[31] != a_q[31]);
                end
                FN_SUB: begin
                    alu_result = a_minus_b;
                    alu_ovf    = (a_q[31] != b_q[31]) && (a_minus_b[31] != a_q[31]);
                end
                FN_AND:  alu_result = a_q & b_q;
                FN_OR:   alu_result = a_q | b_q;
                FN_SLT:  alu_result = {31'd0, $signed(a_q) < $signed(b_q)};
                default: alu_result = '0;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ipc_d       = ipc_q;
        ir_d        = ir_q;
        a_d         = a_q;
        b_d         = b_q;
        aluout_d    = aluout_q;
        mdr_d       = mdr_q;
        epc_d       = epc_q;
        cause_d     = cause_q;
        exc_code_d  = exc_code_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        exc_pulse_d = exc_pulse_q;
        for (int unsigned i = 0; i < 32; i++) regs_d[i] = regs_q[i];

        if (enable) begin
            case (state_q)
                S_FETCH: begin
                    // First FETCH after reset has no request yet; raise it here.
                    if (!mem_req_q) begin
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = pc_q;
                    end else if (mem_ready) begin
                        ir_d      = mem_rdata;
                        ipc_d     = pc_q;
                        pc_d      = pc_q + 32'd4;
                        mem_req_d = 1'b0;
                        state_d   = S_DECODE;
                    end
                end
                S_DECODE: begin
                    a_d      = regs_q[rs];
                    b_d      = regs_q[rt];
                    aluout_d = pc_q + {sext_imm[29:0], 2'b00};
                    if (!insn_valid) begin
                        exc_code_d = EXC_RI;
                        state_d    = S_EXCEPTION;
                    end else if (opcode == OP_J) begin
                        pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    case (opcode)
                        OP_RTYPE, OP_ADDI: begin
                            aluout_d = alu_result;
                            if (alu_ovf) begin
                                exc_code_d = EXC_OV;
                                state_d    = S_EXCEPTION;
                            end else begin
                                state_d = S_WRITEBACK;
                            end
                        end
                        OP_BEQ, OP_BNE: begin
                            if ((a_q == b_q) == (opcode == OP_BEQ)) pc_d = aluout_q;
                            state_d = S_FETCH;
                        end
                        OP_LW, OP_SW: begin
                            aluout_d = a_plus_imm;
                            if (a_plus_imm[1:0] != 2'b00) begin
                                exc_code_d = (opcode == OP_LW) ? EXC_ADEL : EXC_ADES;
                                state_d    = S_EXCEPTION;
                            end else begin
                                state_d = S_MEM;
                            end
                        end
                        default: begin
                            exc_code_d = EXC_RI;
                            state_d    = S_EXCEPTION;
                        end
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) begin
                        mem_req_d = 1'b0;
                        if (opcode == OP_LW) begin
                            mdr_d   = mem_rdata;
                            state_d = S_WRITEBACK;
                        end else begin
                            state_d = S_FETCH;
                        end
                    end
                end
                S_WRITEBACK: begin
                    if (wb_addr != 5'd0) regs_d[wb_addr] = wb_data;
                    state_d = S_FETCH;
                end
                S_EXCEPTION: begin
                    epc_d   = ipc_q;
                    cause_d = exc_code_q;
                    pc_d    = EXC_VECTOR;
                    state_d = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase

            // Requests are launched from the registered port on entry, so the address is stable from cycle one.
            if (state_d != state_q) begin
                if (state_d == S_FETCH) begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = pc_d;
                end else if (state_d == S_MEM) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = (opcode == OP_SW);
                    mem_addr_d  = aluout_d;
                    mem_wdata_d = b_q;
                end
            end
            exc_pulse_d = (state_d == S_EXCEPTION);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            ipc_q       <= '0;
            ir_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            aluout_q    <= '0;
            mdr_q       <= '0;
            epc_q       <= '0;
            cause_q     <= '0;
            exc_code_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            exc_pulse_q <= 1'b0;
            for (int unsigned i = 0; i < 32; i++) regs_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ipc_q       <= ipc_d;
            ir_q        <= ir_d;
            a_q         <= a_d;
            b_q         <= b_d;
            aluout_q    <= aluout_d;
            mdr_q       <= mdr_d;
            epc_q       <= epc_d;
            cause_q     <= cause_d;
            exc_code_q  <= exc_code_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            exc_pulse_q <= exc_pulse_d;
            for (int unsigned i = 0; i < 32; i++) regs_q[i] <= regs_d[i];
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q[ADDR_WIDTH-1:0];
    assign mem_wdata = mem_wdata_q;
    assign pc        = pc_q;
    assign epc       = epc_q;
    assign cause     = cause_q;
    assign exc_pulse = exc_pulse_q;

`ifdef MC_MIPS_PERF_COUNTERS_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d, instret_cnt_q, instret_cnt_d;

    always_comb begin
        cycle_cnt_d   = cycle_cnt_q;
        instret_cnt_d = instret_cnt_q;
        if (enable) begin
            cycle_cnt_d = cycle_cnt_q + 32'd1;
            if (state_d == S_FETCH && state_q inside {S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK})
                instret_cnt_d = instret_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_mips_multi_cycle.sv
// Directed bench for mips_multi_cycle: small programs on a word memory with configurable wait states.
module tb_mips_multi_cycle;

    logic        clk, reset, enable;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] pc, epc;
    logic [4:0]  cause;
    logic        exc_pulse;
`ifdef MC_MIPS_PERF_COUNTERS_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    int unsigned tests, fails;
    int unsigned lat;
    int unsigned wait_cnt;
    int unsigned st_count;
    logic        armed;
    logic [31:0] mem    [256];
    logic [31:0] st_mem [16];

    localparam logic [31:0] VEC  = 32'h8000_0180;
    localparam logic [31:0] LOOP = 32'h1000_FFFF;

    mips_multi_cycle #(
        .RESET_PC  (32'h0000_0000),
        .EXC_VECTOR(VEC),
        .ADDR_WIDTH(32)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .pc       (pc),
        .epc      (epc),
        .cause    (cause),
        .exc_pulse(exc_pulse)
`ifdef MC_MIPS_PERF_COUNTERS_EN
        ,
        .cycle_cnt  (cycle_cnt),
        .instret_cnt(instret_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory responder: ready after lat wait cycles; stores land in st_mem (addresses 0x40-0x7F).
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        wait_cnt  = 0;
        armed     = 1'b0;
        st_count  = 0;
        for (int i = 0; i < 16; i++) st_mem[i] = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!reset) begin
                wait_cnt  = 0;
                mem_ready = 1'b0;
                armed     = 1'b0;
                for (int i = 0; i < 16; i++) st_mem[i] = '0;
            end else begin
                if (armed) wait_cnt = 0;
                if (mem_req && wait_cnt >= lat) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem[mem_addr[9:2]];
                    if (mem_we && enable) begin
                        st_mem[mem_addr[5:2]] = mem_wdata;
                        st_count++;
                    end
                end else begin
                    mem_ready = 1'b0;
                    if (mem_req) wait_cnt++;
                    else wait_cnt = 0;
                end
                armed = mem_ready && enable;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hold_reset();
        @(negedge clk);
        reset  = 1'b0;
        enable = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 256; i++) mem[i] = LOOP;
    endtask

    task automatic release_reset(input int unsigned latency);
        lat = latency;
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        hold_reset();
        tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL rst_req: got %b want 0", mem_req); end
        tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL rst_we: got %b want 0", mem_we); end
        tests++; if (mem_addr !== 32'd0) begin fails++; $display("FAIL rst_addr: got %h want 0", mem_addr); end
        tests++; if (mem_wdata !== 32'd0) begin fails++; $display("FAIL rst_wdata: got %h want 0", mem_wdata); end
        tests++; if (pc !== 32'd0) begin fails++; $display("FAIL rst_pc: got %h want 0", pc); end
        tests++; if (epc !== 32'd0) begin fails++; $display("FAIL rst_epc: got %h want 0", epc); end
        tests++; if (cause !== 5'd0) begin fails++; $display("FAIL rst_cause: got %0d want 0", cause); end
        tests++; if (exc_pulse !== 1'b0) begin fails++; $display("FAIL rst_exc: got %b want 0", exc_pulse); end
        release_reset(0);
        tests++; if (mem_req !== 1'b1 || mem_addr !== 32'd0) begin fails++; $display("FAIL rst_first_fetch: req=%b addr=%h want 1/0", mem_req, mem_addr); end
    endtask

    task automatic test_arith();
        hold_reset();
        mem[0] = 32'h2001_0005;   // addi $1,$0,5
        mem[1] = 32'h2002_0007;   // addi $2,$0,7
        mem[2] = 32'h0022_1820;   // add  $3,$1,$2
        mem[3] = 32'hAC03_0040;   // sw   $3,0x40($0)
        release_reset(0);
        repeat (11) tick();
        tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL arith_wb_noreq: got %b want 0", mem_req); end
        tick();
        tests++; if (pc !== 32'd12 || mem_addr !== 32'd12 || mem_req !== 1'b1 || mem_we !== 1'b0)
            begin fails++; $display("FAIL arith_pc12: pc=%h addr=%h req=%b we=%b want c/c/1/0", pc, mem_addr, mem_req, mem_we); end
`ifdef MC_MIPS_PERF_COUNTERS_EN
        tests++; if (cycle_cnt !== 32'd13 || instret_cnt !== 32'd3)
            begin fails++; $display("FAIL perf_cnt: cyc=%0d ret=%0d want 13/3", cycle_cnt, instret_cnt); end
`endif
        repeat (4) tick();
        tests++; if (st_mem[0] !== 32'd12) begin fails++; $display("FAIL arith_r3: got %h want 0000000c", st_mem[0]); end
        tests++; if (pc !== 32'd16 || mem_addr !== 32'd16) begin fails++; $display("FAIL arith_sw_cpi: pc=%h addr=%h want 10", pc, mem_addr); end
    endtask

    task automatic test_lw_wait();
        hold_reset();
        mem[0] = 32'h8C04_0010;   // lw $4,0x10($0)
        mem[1] = 32'hAC04_0044;   // sw $4,0x44($0)
        mem[4] = 32'hDEAD_BEEF;
        release_reset(3);
        for (int i = 1; i <= 3; i++) begin
            tick();
            tests++; if (mem_req !== 1'b1 || mem_addr !== 32'd0 || mem_we !== 1'b0)
                begin fails++; $display("FAIL lw_fetch_hold%0d: req=%b addr=%h we=%b", i, mem_req, mem_addr, mem_we); end
        end
        tick();
        tests++; if (mem_req !== 1'b0 || pc !== 32'd4) begin fails++; $display("FAIL lw_fetch_done: req=%b pc=%h want 0/4", mem_req, pc); end
        repeat (2) tick();
        for (int i = 1; i <= 3; i++) begin
            tick();
            tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h10 || mem_we !== 1'b0)
                begin fails++; $display("FAIL lw_mem_hold%0d: req=%b addr=%h we=%b", i, mem_req, mem_addr, mem_we); end
        end
        tick();
        tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL lw_mem_done: req=%b want 0", mem_req); end
        tick();
        tests++; if (mem_req !== 1'b1 || mem_addr !== 32'd4) begin fails++; $display("FAIL lw_11cyc: req=%b addr=%h want 1/4", mem_req, mem_addr); end
        repeat (20) tick();
        tests++; if (st_mem[1] !== 32'hDEAD_BEEF) begin fails++; $display("FAIL lw_r4: got %h want deadbeef", st_mem[1]); end
    endtask

    task automatic test_branch();
        hold_reset();
        mem[0] = 32'h0800_0008;   // j 0x20; beq $0,$0,-1 sits at 0x20 from the fill
        release_reset(0);
        repeat (2) tick();
        tests++; if (pc !== 32'h20 || mem_addr !== 32'h20) begin fails++; $display("FAIL j_target: pc=%h addr=%h want 20", pc, mem_addr); end
        tick();
        tests++; if (pc !== 32'h24) begin fails++; $display("FAIL beq_fetch: pc=%h want 24", pc); end
        repeat (2) tick();
        tests++; if (pc !== 32'h20 || mem_req !== 1'b1) begin fails++; $display("FAIL beq_taken: pc=%h req=%b want 20/1", pc, mem_req); end
        repeat (3) tick();
        tests++; if (pc !== 32'h20 || mem_addr !== 32'h20) begin fails++; $display("FAIL beq_loop: pc=%h addr=%h want 20", pc, mem_addr); end

        hold_reset();
        mem[0] = 32'h0800_0008;   // j 0x20
        mem[8] = 32'h1400_0004;   // bne $0,$0,+4
        release_reset(0);
        repeat (5) tick();
        tests++; if (pc !== 32'h24 || mem_addr !== 32'h24) begin fails++; $display("FAIL bne_not_taken: pc=%h addr=%h want 24", pc, mem_addr); end
    endtask

    task automatic test_overflow();
        hold_reset();
        mem[0]    = 32'h2005_7FFF;   // addi $5,$0,0x7FFF
        mem[1]    = 32'h8C06_0014;   // lw   $6,0x14($0)
        mem[2]    = 32'h00A6_2820;   // add  $5,$5,$6 -> overflow
        mem[5]    = 32'h7FFF_FFFF;
        mem[8'h60] = 32'hAC05_0048;  // vector: sw $5,0x48($0)
        release_reset(0);
        repeat (11) tick();
        tests++; if (cause !== 5'd0 || exc_pulse !== 1'b0) begin fails++; $display("FAIL ovf_pre: cause=%0d exc=%b want 0/0", cause, exc_pulse); end
        tick();
        tests++; if (exc_pulse !== 1'b1) begin fails++; $display("FAIL ovf_pulse: got %b want 1", exc_pulse); end
        tick();
        tests++; if (exc_pulse !== 1'b0) begin fails++; $display("FAIL ovf_pulse_len: got %b want 0", exc_pulse); end
        tests++; if (cause !== 5'd12 || epc !== 32'd8) begin fails++; $display("FAIL ovf_capture: cause=%0d epc=%h want 12/8", cause, epc); end
        tests++; if (pc !== VEC || mem_addr !== VEC) begin fails++; $display("FAIL ovf_vector: pc=%h addr=%h want %h", pc, mem_addr, VEC); end
        repeat (10) tick();
        tests++; if (st_mem[2] !== 32'h0000_7FFF) begin fails++; $display("FAIL ovf_r5_kept: got %h want 00007fff", st_mem[2]); end
    endtask

    task automatic test_exceptions();
        hold_reset();
        mem[0]     = 32'hFC00_0000;  // opcode 0x3F
        mem[8'h60] = 32'h8C01_0002;  // vector: lw $1,2($0)
        release_reset(0);
        repeat (2) tick();
        tests++; if (exc_pulse !== 1'b1 || cause !== 5'd0) begin fails++; $display("FAIL ri_pulse: exc=%b cause=%0d want 1/0", exc_pulse, cause); end
        tick();
        tests++; if (cause !== 5'd10 || epc !== 32'd0 || pc !== VEC) begin fails++; $display("FAIL ri_capture: cause=%0d epc=%h pc=%h", cause, epc, pc); end
        repeat (3) tick();
        tests++; if (exc_pulse !== 1'b1 || cause !== 5'd10) begin fails++; $display("FAIL adel_pulse: exc=%b cause=%0d want 1/10", exc_pulse, cause); end
        tick();
        tests++; if (cause !== 5'd4 || epc !== VEC || pc !== VEC) begin fails++; $display("FAIL adel_capture: cause=%0d epc=%h pc=%h", cause, epc, pc); end
    endtask

    task automatic test_reset_freeze();
        int unsigned st_before;
        bit          done;
        hold_reset();
        mem[0] = 32'hAC00_0040;   // sw $0,0x40($0)
        release_reset(3);
        repeat (7) tick();
        tests++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h40)
            begin fails++; $display("FAIL sw_wait: req=%b we=%b addr=%h want 1/1/40", mem_req, mem_we, mem_addr); end
        st_before = st_count;
        @(negedge clk);
        reset = 1'b0;
        tick();
        tests++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'd0 || pc !== 32'd0)
            begin fails++; $display("FAIL midwait_reset: req=%b we=%b addr=%h pc=%h want all 0", mem_req, mem_we, mem_addr, pc); end
        tests++; if (st_count !== st_before) begin fails++; $display("FAIL midwait_nowrite: got %0d want %0d", st_count, st_before); end
        @(negedge clk);
        reset = 1'b1;
        tick();
        @(negedge clk);
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++; if (mem_req !== 1'b1 || mem_addr !== 32'd0 || mem_we !== 1'b0 || pc !== 32'd0)
                begin fails++; $display("FAIL freeze%0d: req=%b addr=%h we=%b pc=%h", i, mem_req, mem_addr, mem_we, pc); end
        end
        @(negedge clk);
        enable = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            tick();
            if (mem_req === 1'b0) done = 1'b1;
        end
        tests++; if (!done) begin fails++; $display("FAIL unfreeze_timeout: req still %b", mem_req); end
        tests++; if (pc !== 32'd4) begin fails++; $display("FAIL unfreeze_pc: got %h want 4", pc); end
    endtask

    initial begin
        reset  = 1'b0;
        enable = 1'b1;
        lat    = 0;
        tests  = 0;
        fails  = 0;
        for (int i = 0; i < 256; i++) mem[i] = LOOP;
        test_reset();
        test_arith();
        test_lw_wait();
        test_branch();
        test_overflow();
        test_exceptions();
        test_reset_freeze();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
